row_chunk_feeder: RTL and testbench

Initiator/producer side of the row-by-vector handshake. Reads matrix rows and the dense vector from two synchronous ROMs in NI-element chunks, drives them into the row-by-vector dot-product engine, and answers each chunk request. It captures one scalar result per row and streams it out with its row index. One instance sits in front of each row-by-vector engine in the matrix-vector datapath.

---
 rtl/row_vec_pkg.sv | 21 ++
 rtl/chunk_addr_gen.sv | 50 +++++
 rtl/row_chunk_feeder.sv | 159 +++++++++++++++
 tb/tb_row_chunk_feeder.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/row_vec_pkg.sv
// row_vec_pkg: widths and FSM encoding shared by the row-by-vector
// chunk feeder and its address generator.
package row_vec_pkg;

   localparam int NI            = 8;
   localparam int element_width = 32;
   localparam int AW            = 16;
   localparam int CW            = NI * element_width;

   typedef enum logic [2:0] {
      IDLE,
      ROW_WAIT,
      FETCH,
      LOAD,
      PRESENT,
      WAIT_REQ,
      WAIT_RES,
      FINISH
   } state_t;

endpackage

// File: rtl/chunk_addr_gen.sv
// chunk_addr_gen: running matrix pointer, chunk index and row index
// for the chunk feeder, plus first/last chunk and last-row flags.
module chunk_addr_gen
   import row_vec_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          next_chunk,
   input  logic          next_row,
   input  logic [31:0]   no_of_multiples,
   input  logic [AW-1:0] no_of_rows,
   output logic [AW-1:0] mat_ptr,
   output logic [AW-1:0] chunk_idx,
   output logic [AW-1:0] row_idx,
   output logic          first_chunk,
   output logic          all_sent,
   output logic          last_row
);

   logic [31:0] k;

   // mat_ptr never rewinds between rows, so it tracks row*mults+k
   always_ff @(posedge clk) begin
      if (reset) begin
         mat_ptr <= '0;
         k       <= '0;
         row_idx <= '0;
      end else if (clear) begin
         mat_ptr <= '0;
         k       <= '0;
         row_idx <= '0;
      end else begin
         if (next_chunk) begin
            mat_ptr <= mat_ptr + 1'b1;
            k       <= k + 32'd1;
         end
         if (next_row) begin
            k       <= '0;
            row_idx <= row_idx + 1'b1;
         end
      end
   end

   assign chunk_idx   = k[AW-1:0];
   assign first_chunk = (k == '0);
   assign all_sent    = (k == no_of_multiples);
   assign last_row    = (row_idx == no_of_rows - 1'b1);

endmodule

// File: rtl/row_chunk_feeder.sv
// row_chunk_feeder: fetches matrix/vector chunks from ROM, hands them
// to the row-by-vector engine and streams back one result per row.
module row_chunk_feeder
   import row_vec_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     go,
   input  logic [AW-1:0]            no_of_rows,
   input  logic [31:0]              no_of_multiples,
   output logic [AW-1:0]            mat_addr,
   output logic [AW-1:0]            vec_addr,
   output logic                     mem_rd_en,
   input  logic [CW-1:0]            mat_data,
   input  logic [CW-1:0]            vec_data,
   output logic [CW-1:0]            a,
   output logic [CW-1:0]            p,
   output logic                     start_row_by_vector,
   output logic                     you_can_read,
   input  logic                     give_me_only,
   input  logic                     decoder_read_now,
   input  logic [element_width-1:0] result,
   input  logic                     I_am_ready,
   output logic                     res_valid,
   output logic [element_width-1:0] res_data,
   output logic [AW-1:0]            res_row,
   output logic                     busy,
   output logic                     done,
   output logic                     proto_err
);

   state_t        state;
   state_t        state_nx;
   logic [AW-1:0] rows_q;
   logic [31:0]   mults_q;
   logic          first_q;

   logic          start_go;
   logic          zero_job;
   logic          take_req;
   logic          accept_res;
   logic          stray_req;
   logic          stray_res;

   logic [AW-1:0] mat_ptr;
   logic [AW-1:0] chunk_idx;
   logic [AW-1:0] row_idx;
   logic          first_chunk;
   logic          all_sent;
   logic          last_row;

   assign start_go   = (state == IDLE) && go;
   assign zero_job   = (no_of_rows == '0)
                    || (no_of_multiples == '0);
   assign take_req   = (state == WAIT_REQ) && give_me_only;
   assign accept_res = (state == WAIT_RES) && decoder_read_now;
   assign stray_req  = give_me_only && (state != WAIT_REQ);
   assign stray_res  = decoder_read_now && (state != WAIT_RES);

   chunk_addr_gen u_addr (
      .clk             (clk),
      .reset           (reset),
      .clear           (start_go),
      .next_chunk      (state == LOAD),
      .next_row        (accept_res),
      .no_of_multiples (mults_q),
      .no_of_rows      (rows_q),
      .mat_ptr         (mat_ptr),
      .chunk_idx       (chunk_idx),
      .row_idx         (row_idx),
      .first_chunk     (first_chunk),
      .all_sent        (all_sent),
      .last_row        (last_row)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (go) state_nx = zero_job ? FINISH : ROW_WAIT;
         end
         ROW_WAIT: begin
            if (I_am_ready) state_nx = FETCH;
         end
         FETCH:   state_nx = LOAD;
         LOAD:    state_nx = PRESENT;
         PRESENT: state_nx = all_sent ? WAIT_RES : WAIT_REQ;
         WAIT_REQ: begin
            if (take_req) state_nx = FETCH;
         end
         WAIT_RES: begin
            if (accept_res)
               state_nx = last_row ? FINISH : ROW_WAIT;
         end
         FINISH:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      mat_addr            = '0;
      vec_addr            = '0;
      mem_rd_en           = 1'b0;
      you_can_read        = 1'b0;
      start_row_by_vector = 1'b0;
      busy                = (state != IDLE);
      unique case (state)
         FETCH: begin
            mem_rd_en = 1'b1;
            mat_addr  = mat_ptr;
            vec_addr  = chunk_idx;
         end
         PRESENT: begin
            you_can_read        = 1'b1;
            start_row_by_vector = first_q;
         end
         default: ;
      endcase
   end

   // done trails FINISH by a cycle so it lands after the last res_valid
   always_ff @(posedge clk) begin
      if (reset) begin
         rows_q    <= '0;
         mults_q   <= '0;
         a         <= '0;
         p         <= '0;
         first_q   <= 1'b0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_row   <= '0;
         done      <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         if (start_go) begin
            rows_q  <= no_of_rows;
            mults_q <= no_of_multiples;
         end
         if (state == LOAD) begin
            a       <= mat_data;
            p       <= vec_data;
            first_q <= first_chunk;
         end
         res_valid <= accept_res;
         if (accept_res) begin
            res_data <= result;
            res_row  <= row_idx;
         end
         done <= (state == FINISH);
         if (stray_req || stray_res) proto_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_row_chunk_feeder.sv
// tb_row_chunk_feeder: directed bench with a ROM model and a hand-driven
// engine; expected addresses, chunks and results are computed locally.
module tb_row_chunk_feeder;
   import row_vec_pkg::*;

   logic                     clk = 1'b0;
   logic                     reset;
   logic                     go;
   logic [AW-1:0]            no_of_rows;
   logic [31:0]              no_of_multiples;
   logic [AW-1:0]            mat_addr;
   logic [AW-1:0]            vec_addr;
   logic                     mem_rd_en;
   logic [CW-1:0]            mat_data = '0;
   logic [CW-1:0]            vec_data = '0;
   logic [CW-1:0]            a;
   logic [CW-1:0]            p;
   logic                     start_row_by_vector;
   logic                     you_can_read;
   logic                     give_me_only;
   logic                     decoder_read_now;
   logic [element_width-1:0] result;
   logic                     I_am_ready;
   logic                     res_valid;
   logic [element_width-1:0] res_data;
   logic [AW-1:0]            res_row;
   logic                     busy;
   logic                     done;
   logic                     proto_err;

   int checks = 0;
   int errors = 0;
   int n_done = 0;
   int n_rd   = 0;
   int n_res  = 0;
   int s_done, s_rd, s_res;

   logic [31:0] fvals [4] = '{32'h3F800000, 32'h40000000,
                              32'h40400000, 32'h40800000};

   row_chunk_feeder dut (
      .clk                 (clk),
      .reset               (reset),
      .go                  (go),
      .no_of_rows          (no_of_rows),
      .no_of_multiples     (no_of_multiples),
      .mat_addr            (mat_addr),
      .vec_addr            (vec_addr),
      .mem_rd_en           (mem_rd_en),
      .mat_data            (mat_data),
      .vec_data            (vec_data),
      .a                   (a),
      .p                   (p),
      .start_row_by_vector (start_row_by_vector),
      .you_can_read        (you_can_read),
      .give_me_only        (give_me_only),
      .decoder_read_now    (decoder_read_now),
      .result              (result),
      .I_am_ready          (I_am_ready),
      .res_valid           (res_valid),
      .res_data            (res_data),
      .res_row             (res_row),
      .busy                (busy),
      .done                (done),
      .proto_err           (proto_err)
   );

   always #5 clk = ~clk;

   // synchronous ROMs: data one cycle after the read strobe
   always @(posedge clk) begin
      if (mem_rd_en) begin
         mat_data <= {NI{16'hA5A5, mat_addr}};
         vec_data <= {NI{16'hB00B, vec_addr}};
      end
   end

   always @(posedge clk) begin
      if (done)      n_done <= n_done + 1;
      if (mem_rd_en) n_rd   <= n_rd + 1;
      if (res_valid) n_res  <= n_res + 1;
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   function automatic logic [CW-1:0] ea(input int m);
      logic [15:0] mm;
      mm = m[15:0];
      return {NI{16'hA5A5, mm}};
   endfunction

   function automatic logic [CW-1:0] ep(input int v);
      logic [15:0] vv;
      vv = v[15:0];
      return {NI{16'hB00B, vv}};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [CW-1:0] obs,
                      input logic [CW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // step to the next FETCH, then through LOAD into PRESENT
   task automatic fp(input int m, input int v,
                     input logic st, input int lat_exp);
      int lat;
      lat = 0;
      do begin
         step();
         give_me_only     = 1'b0;
         decoder_read_now = 1'b0;
         go               = 1'b0;
         lat++;
      end while (!mem_rd_en && lat < 30);
      chk("fetch_lat", lat, lat_exp);
      chk("mem_rd_en", mem_rd_en, 1'b1);
      chk("mat_addr", mat_addr, m);
      chk("vec_addr", vec_addr, v);
      step();
      chk("load_rd_low", mem_rd_en, 1'b0);
      chk("load_ycr_low", you_can_read, 1'b0);
      step();
      chk("you_can_read", you_can_read, 1'b1);
      chk("start_rbv", start_row_by_vector, st);
      chk("a_chunk", a, ea(m));
      chk("p_chunk", p, ep(v));
   endtask

   // engine asks for the next chunk 2 cycles after you_can_read
   task automatic req(input int m, input int v, input logic st);
      step();
      step();
      give_me_only = 1'b1;
      fp(m, v, st, 1);
   endtask

   // called in PRESENT of a row's last chunk
   task automatic res(input logic [31:0] val, input int row,
                      input logic last);
      step();
      decoder_read_now = 1'b1;
      result           = val;
      step();
      decoder_read_now = 1'b0;
      chk("res_valid", res_valid, 1'b1);
      chk("res_data", res_data, val);
      chk("res_row", res_row, row);
      if (last) begin
         step();
         chk("done", done, 1'b1);
         chk("busy_end", busy, 1'b0);
      end
   endtask

   initial begin
      reset            = 1'b1;
      go               = 1'b0;
      no_of_rows       = '0;
      no_of_multiples  = '0;
      give_me_only     = 1'b0;
      decoder_read_now = 1'b0;
      result           = '0;
      I_am_ready       = 1'b0;
      step();
      step();
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_a", a, '0);
      chk("rst_p", p, '0);
      chk("rst_rd", mem_rd_en, 1'b0);
      chk("rst_ycr", you_can_read, 1'b0);
      chk("rst_res_valid", res_valid, 1'b0);
      chk("rst_proto", proto_err, 1'b0);
      chk("rst_mat_addr", mat_addr, '0);
      reset = 1'b0;
      step();

      // two rows of three chunks
      s_done = n_done; s_rd = n_rd; s_res = n_res;
      I_am_ready      = 1'b1;
      no_of_rows      = 2;
      no_of_multiples = 3;
      go              = 1'b1;
      fp(0, 0, 1'b1, 2);
      step();
      go         = 1'b1;
      no_of_rows = 7;
      step();
      go           = 1'b0;
      no_of_rows   = 2;
      give_me_only = 1'b1;
      fp(1, 1, 1'b0, 1);
      req(2, 2, 1'b0);
      res(32'h11111111, 0, 1'b0);
      fp(3, 0, 1'b1, 1);
      req(4, 1, 1'b0);
      req(5, 2, 1'b0);
      res(32'h22222222, 1, 1'b1);
      step();
      chk("t1_done_low", done, 1'b0);
      chk("t1_done_once", n_done - s_done, 1);
      chk("t1_reads", n_rd - s_rd, 6);
      chk("t1_results", n_res - s_res, 2);
      chk("t1_proto", proto_err, 1'b0);

      // single-chunk rows
      s_res           = n_res;
      no_of_rows      = 4;
      no_of_multiples = 1;
      go              = 1'b1;
      for (int r = 0; r < 4; r++) begin
         fp(r, 0, 1'b1, (r == 0) ? 2 : 1);
         res(fvals[r], r, r == 3);
      end
      step();
      chk("t2_results", n_res - s_res, 4);
      chk("t2_proto", proto_err, 1'b0);

      // zero-sized jobs
      s_done = n_done; s_rd = n_rd; s_res = n_res;
      no_of_rows      = 0;
      no_of_multiples = 5;
      go              = 1'b1;
      step();
      go = 1'b0;
      chk("t3a_busy", busy, 1'b1);
      chk("t3a_done_early", done, 1'b0);
      step();
      chk("t3a_done", done, 1'b1);
      step();
      no_of_rows      = 3;
      no_of_multiples = 0;
      go              = 1'b1;
      step();
      go = 1'b0;
      step();
      chk("t3b_done", done, 1'b1);
      step();
      chk("t3_reads", n_rd - s_rd, 0);
      chk("t3_results", n_res - s_res, 0);
      chk("t3_dones", n_done - s_done, 2);

      // engine not ready, then protocol errors
      reset = 1'b1;
      step();
      reset = 1'b0;
      s_rd  = n_rd;
      I_am_ready      = 1'b0;
      no_of_rows      = 1;
      no_of_multiples = 2;
      go              = 1'b1;
      step();
      go = 1'b0;
      repeat (10) step();
      chk("t4_no_reads", n_rd - s_rd, 0);
      chk("t4_a_zero", a, '0);
      chk("t4_p_zero", p, '0);
      chk("t4_busy", busy, 1'b1);
      I_am_ready = 1'b1;
      fp(0, 0, 1'b1, 1);
      step();
      chk("t5_proto_clear", proto_err, 1'b0);
      s_res            = n_res;
      decoder_read_now = 1'b1;
      result           = 32'hDEADBEEF;
      step();
      decoder_read_now = 1'b0;
      chk("t5_proto_res", proto_err, 1'b1);
      chk("t5_no_res", res_valid, 1'b0);
      give_me_only = 1'b1;
      fp(1, 1, 1'b0, 1);
      step();
      give_me_only = 1'b1;
      step();
      give_me_only = 1'b0;
      chk("t5_proto_req", proto_err, 1'b1);
      chk("t5_no_fetch", mem_rd_en, 1'b0);
      chk("t5_no_ycr", you_can_read, 1'b0);
      decoder_read_now = 1'b1;
      result           = 32'h12345678;
      step();
      decoder_read_now = 1'b0;
      chk("t5_res_valid", res_valid, 1'b1);
      chk("t5_res_data", res_data, 32'h12345678);
      chk("t5_res_row", res_row, 0);
      step();
      chk("t5_done", done, 1'b1);
      chk("t5_proto_sticky", proto_err, 1'b1);
      chk("t5_results", n_res - s_res, 1);
      step();

      // reset in WAIT_REQ of row 1
      no_of_rows      = 2;
      no_of_multiples = 2;
      go              = 1'b1;
      fp(0, 0, 1'b1, 2);
      req(1, 1, 1'b0);
      res(32'hAAAA5555, 0, 1'b0);
      fp(2, 0, 1'b1, 1);
      step();
      s_done = n_done; s_res = n_res;
      reset  = 1'b1;
      step();
      reset = 1'b0;
      chk("t6_busy", busy, 1'b0);
      chk("t6_a", a, '0);
      chk("t6_p", p, '0);
      chk("t6_proto", proto_err, 1'b0);
      chk("t6_rd", mem_rd_en, 1'b0);
      chk("t6_ycr", you_can_read, 1'b0);
      chk("t6_done", done, 1'b0);
      chk("t6_res_valid", res_valid, 1'b0);
      chk("t6_res_data", res_data, '0);
      repeat (3) step();
      chk("t6_no_done", n_done - s_done, 0);
      chk("t6_no_res", n_res - s_res, 0);
      no_of_rows      = 1;
      no_of_multiples = 1;
      go              = 1'b1;
      fp(0, 0, 1'b1, 2);
      res(32'hBBBB0000, 0, 1'b1);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
